grid_sprite_renderer: RTL and testbench

- Pipelined renderer for the kitchen object grid.
- For each pixel it locates the grid cell under the beam, reads that cell's object state from the object-grid RAM, and fetches the matching sprite texel from a shared sprite ROM.
- Outputs an object-layer pixel with a valid/opaque flag for the top-level compositor.
- Generalises grid size, tile size and origin, and adds per-state two-frame animation (e.g. fire).

---
 rtl/grid_sprite_renderer.sv | 145 ++++++++++++++
 tb/tb_grid_sprite_renderer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_sprite_renderer.sv
// rtl/grid_sprite_renderer.sv - 3-stage object-grid sprite renderer (cell lookup, sprite fetch, pixel out)
// Optional tile-border cursor outline enabled by defining GRID_CURSOR_EN.
module grid_sprite_renderer #(
    parameter int                            GRID_COLS    = 8,
    parameter int                            GRID_ROWS    = 8,
    parameter int                            TILE_LOG2    = 5,
    parameter int                            ORIGIN_X     = 112,
    parameter int                            ORIGIN_Y     = 112,
    parameter int                            STATE_W      = 4,
    parameter logic [(1 << STATE_W)-1:0]     ANIM_MASK    = 16'h0300,
    parameter int                            ANIM_DIV     = 15,
    parameter logic [11:0]                   CURSOR_COLOR = 12'hFFF
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic [10:0]                             hcount_in,
    input  logic [9:0]                              vcount_in,
    input  logic                                    frame_tick_in,
    output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0]  cell_addr_out,
    input  logic [STATE_W-1:0]                      cell_state_in,
    output logic [STATE_W+2*TILE_LOG2:0]            sprite_addr_out,
    input  logic [11:0]                             sprite_data_in,
    output logic [11:0]                             pixel_out,
    output logic                                    pixel_valid_out
`ifdef GRID_CURSOR_EN
    ,
    input  logic [$clog2(GRID_COLS)-1:0]            cursor_col_in,
    input  logic [$clog2(GRID_ROWS)-1:0]            cursor_row_in
`endif
);

    localparam int ADDR_W    = $clog2(GRID_COLS*GRID_ROWS);
    localparam int SPR_W     = STATE_W + 1 + 2*TILE_LOG2;
    localparam int GRID_W_PX = GRID_COLS << TILE_LOG2;
    localparam int GRID_H_PX = GRID_ROWS << TILE_LOG2;
    localparam int CNT_W     = $clog2(ANIM_DIV + 1);

    logic [10:0]          dx, dy, col, row;
    logic                 in_grid;
    logic                 frame_sel;

    logic [ADDR_W-1:0]    cell_addr_d, cell_addr_q;
    logic                 in_grid_s1_d, in_grid_s1_q;
    logic [TILE_LOG2-1:0] row_off_s1_d, row_off_s1_q;
    logic [TILE_LOG2-1:0] col_off_s1_d, col_off_s1_q;
    logic [SPR_W-1:0]     sprite_addr_d, sprite_addr_q;
    logic                 in_grid_s2_d, in_grid_s2_q;
    logic                 occupied_s2_d, occupied_s2_q;
    logic [11:0]          pixel_d, pixel_q;
    logic                 pixel_valid_d, pixel_valid_q;
    logic [CNT_W-1:0]     anim_cnt_d, anim_cnt_q;
    logic                 anim_frame_d, anim_frame_q;
`ifdef GRID_CURSOR_EN
    logic                 cursor_s1_d, cursor_s1_q;
    logic                 cursor_s2_d, cursor_s2_q;
`endif

    always_comb begin
        // S0: the explicit >= compares stop beam positions left of/above the grid aliasing via wrap
        dx = hcount_in - 11'(ORIGIN_X);
        dy = {1'b0, vcount_in} - 11'(ORIGIN_Y);
        in_grid = (32'(hcount_in) >= ORIGIN_X) && (32'(dx) < GRID_W_PX) &&
                  (32'(vcount_in) >= ORIGIN_Y) && (32'(dy) < GRID_H_PX);
        col = dx >> TILE_LOG2;
        row = dy >> TILE_LOG2;
        cell_addr_d  = in_grid ? ADDR_W'(32'(row) * GRID_COLS + 32'(col)) : '0;
        in_grid_s1_d = in_grid;
        row_off_s1_d = dy[TILE_LOG2-1:0];
        col_off_s1_d = dx[TILE_LOG2-1:0];

        // S1
        frame_sel     = anim_frame_q & ANIM_MASK[cell_state_in];
        sprite_addr_d = {cell_state_in, frame_sel, row_off_s1_q, col_off_s1_q};
        in_grid_s2_d  = in_grid_s1_q;
        occupied_s2_d = (cell_state_in != '0);

        // S2: a zero texel is transparent, so it naturally yields pixel 0
        pixel_d = (in_grid_s2_q && occupied_s2_q) ? sprite_data_in : 12'h000;
`ifdef GRID_CURSOR_EN
        cursor_s1_d = in_grid &&
                      (col[$clog2(GRID_COLS)-1:0] == cursor_col_in) &&
                      (row[$clog2(GRID_ROWS)-1:0] == cursor_row_in) &&
                      ((dx[TILE_LOG2-1:0] == '0) || (dx[TILE_LOG2-1:0] == '1) ||
                       (dy[TILE_LOG2-1:0] == '0) || (dy[TILE_LOG2-1:0] == '1));
        cursor_s2_d = cursor_s1_q;
        if (cursor_s2_q) begin
            pixel_d = CURSOR_COLOR;
        end
`endif
        pixel_valid_d = (pixel_d != 12'h000);

        anim_cnt_d   = anim_cnt_q;
        anim_frame_d = anim_frame_q;
        if (frame_tick_in) begin
            if (anim_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                anim_cnt_d   = '0;
                anim_frame_d = ~anim_frame_q;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cell_addr_q   <= '0;
            in_grid_s1_q  <= 1'b0;
            row_off_s1_q  <= '0;
            col_off_s1_q  <= '0;
            sprite_addr_q <= '0;
            in_grid_s2_q  <= 1'b0;
            occupied_s2_q <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            anim_cnt_q    <= '0;
            anim_frame_q  <= 1'b0;
`ifdef GRID_CURSOR_EN
            cursor_s1_q   <= 1'b0;
            cursor_s2_q   <= 1'b0;
`endif
        end else begin
            cell_addr_q   <= cell_addr_d;
            in_grid_s1_q  <= in_grid_s1_d;
            row_off_s1_q  <= row_off_s1_d;
            col_off_s1_q  <= col_off_s1_d;
            sprite_addr_q <= sprite_addr_d;
            in_grid_s2_q  <= in_grid_s2_d;
            occupied_s2_q <= occupied_s2_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            anim_cnt_q    <= anim_cnt_d;
            anim_frame_q  <= anim_frame_d;
`ifdef GRID_CURSOR_EN
            cursor_s1_q   <= cursor_s1_d;
            cursor_s2_q   <= cursor_s2_d;
`endif
        end
    end

    assign cell_addr_out   = cell_addr_q;
    assign sprite_addr_out = sprite_addr_q;
    assign pixel_out       = pixel_q;
    assign pixel_valid_out = pixel_valid_q;

endmodule

// File: tb/tb_grid_sprite_renderer.sv
// tb/tb_grid_sprite_renderer.sv - randomized self-checking bench for grid_sprite_renderer
module tb_grid_sprite_renderer;

    localparam int OX = 112, OY = 112, COLS = 8, ROWS = 8, TILE = 32, DIV = 2;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        frame_tick_in;
    logic [5:0]  cell_addr_out;
    logic [3:0]  cell_state_in;
    logic [14:0] sprite_addr_out;
    logic [11:0] sprite_data_in;
    logic [11:0] pixel_out;
    logic        pixel_valid_out;
`ifdef GRID_CURSOR_EN
    logic [2:0]  cursor_col_in;
    logic [2:0]  cursor_row_in;
`endif

    always #5 clk_in = ~clk_in;

    logic [3:0] grid_ram [64];
    int n_tests = 0;
    int n_fail  = 0;
    int ticks   = 0;
    int exp_seq [6] = '{0, 0, 1, 1, 0, 0};

    typedef struct {
        int h;
        int v;
        bit ing;
        int addr;
        int saddr;
        int pix;
    } exp_t;
    exp_t q[$];

    function automatic logic [11:0] rom_val(int a);
        if (a == 2048) return 12'hB70;
        if (a % 7 == 0) return 12'h000;
        return 12'((a * 37 + 11) | 1);
    endfunction

    assign cell_state_in  = grid_ram[cell_addr_out];
    assign sprite_data_in = rom_val(int'(sprite_addr_out));

    grid_sprite_renderer #(.ANIM_DIV(DIV)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .frame_tick_in   (frame_tick_in),
        .cell_addr_out   (cell_addr_out),
        .cell_state_in   (cell_state_in),
        .sprite_addr_out (sprite_addr_out),
        .sprite_data_in  (sprite_data_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out)
`ifdef GRID_CURSOR_EN
        ,
        .cursor_col_in   (cursor_col_in),
        .cursor_row_in   (cursor_row_in)
`endif
    );

    // Reference: what the object layer shows at beam (h,v), from grid/tile arithmetic
    function automatic exp_t model(int h, int v);
        exp_t e;
        int c, r, s, f, ox, oy;
        e.h = h; e.v = v;
        e.ing = (h >= OX) && (h < OX + COLS*TILE) && (v >= OY) && (v < OY + ROWS*TILE);
        e.addr = 0; e.saddr = 0; e.pix = 0;
        if (e.ing) begin
            c  = (h - OX) / TILE;
            r  = (v - OY) / TILE;
            ox = (h - OX) % TILE;
            oy = (v - OY) % TILE;
            e.addr = r*COLS + c;
            s = int'(grid_ram[e.addr]);
            f = (s == 8 || s == 9) ? (ticks / DIV) % 2 : 0;
            e.saddr = ((s*2 + f)*TILE + oy)*TILE + ox;
            if (s != 0) e.pix = int'(rom_val(e.saddr));
`ifdef GRID_CURSOR_EN
            if (c == int'(cursor_col_in) && r == int'(cursor_row_in) &&
                (ox == 0 || ox == TILE-1 || oy == 0 || oy == TILE-1))
                e.pix = 12'hFFF;
`endif
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v);
        @(posedge clk_in); #1;
        if (q.size() >= 1) check_eq("cell_addr", 32'(cell_addr_out), q[$].addr);
        if (q.size() >= 2 && q[$-1].ing) check_eq("sprite_addr", 32'(sprite_addr_out), q[$-1].saddr);
        if (q.size() >= 3) begin
            check_eq("pixel", 32'(pixel_out), q[$-2].pix);
            check_eq("valid", 32'(pixel_valid_out), 32'(q[$-2].pix != 0));
        end
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        q.push_back(model(h, v));
        if (q.size() > 3) void'(q.pop_front());
    endtask

    task automatic flush();
        repeat (4) drive(0, 0);
        q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in); #1 frame_tick_in = 1'b1;
            @(posedge clk_in); #1 frame_tick_in = 1'b0;
            ticks++;
        end
    endtask

    task automatic fill_ram(input int s);
        for (int i = 0; i < 64; i++) grid_ram[i] = 4'(s);
    endtask

    initial begin
        rst_n_in = 1'b0; frame_tick_in = 1'b0; hcount_in = '0; vcount_in = '0;
`ifdef GRID_CURSOR_EN
        cursor_col_in = '0; cursor_row_in = '0;
`endif
        fill_ram(0);
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst_pixel", 32'(pixel_out), 0);
        check_eq("rst_valid", 32'(pixel_valid_out), 0);
        check_eq("rst_cell_addr", 32'(cell_addr_out), 0);
        check_eq("rst_sprite_addr", 32'(sprite_addr_out), 0);
        rst_n_in = 1'b1;

        // Empty grid sweep along one line
        for (int h = 0; h < 1024; h++) drive(h, 112);
        flush();

        // Single occupied cell (2,1)
        grid_ram[10] = 4'd1;
        drive(176, 144);
        q.delete();
        @(posedge clk_in); #1 check_eq("dir_cell_addr", 32'(cell_addr_out), 10);
        @(posedge clk_in); #1 check_eq("dir_sprite_off", 32'(sprite_addr_out[9:0]), 0);
        @(posedge clk_in); #1;
        check_eq("dir_pixel", 32'(pixel_out), 32'h0B70);
        check_eq("dir_valid", 32'(pixel_valid_out), 1);
        flush();

        // Grid edges with every cell occupied
        fill_ram(1);
        drive(111, 200); drive(368, 200); drive(367, 200); drive(112, 200);
        drive(112, 111); drive(112, 368); drive(367, 367); drive(115, 112);
        flush();

        // Random grid contents and beam positions, with occasional frame ticks
        for (int i = 0; i < 64; i++) grid_ram[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                flush();
                tick($urandom_range(0, 3));
            end
            drive($urandom_range(90, 400), $urandom_range(90, 400));
        end
        flush();

        // Animation: reset clears the frame, then walk through ticks
        rst_n_in = 1'b0; ticks = 0;
        #3 rst_n_in = 1'b1;
        grid_ram[0] = 4'd9; grid_ram[1] = 4'd1;
        for (int k = 0; k < 6; k++) begin
            q.delete();
            repeat (3) drive(112, 112);
            check_eq("anim_frame_s9", 32'(sprite_addr_out[10]), exp_seq[k]);
            repeat (3) drive(144, 112);
            check_eq("anim_frame_s1", 32'(sprite_addr_out[10]), 0);
            flush();
            if (k < 5) tick(1);
        end

        // Reset in the middle of a line
        fill_ram(1);
        for (int h = 112; h < 200; h++) drive(h, 130);
        @(posedge clk_in); #2 rst_n_in = 1'b0;
        ticks = 0;
        #1;
        check_eq("mid_rst_pixel", 32'(pixel_out), 0);
        check_eq("mid_rst_valid", 32'(pixel_valid_out), 0);
        check_eq("mid_rst_sprite_addr", 32'(sprite_addr_out), 0);
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        hcount_in = 11'd112; vcount_in = 10'd112;
        q.delete();
        repeat (2) begin
            @(posedge clk_in); #1;
            check_eq("post_rst_pixel", 32'(pixel_out), 0);
            check_eq("post_rst_valid", 32'(pixel_valid_out), 0);
        end
        @(posedge clk_in); #1;
        check_eq("post_rst_pixel_live", 32'(pixel_out), model(112, 112).pix);
        check_eq("post_rst_valid_live", 32'(pixel_valid_out), 1);
        flush();

`ifdef GRID_CURSOR_EN
        drive(112, 112); drive(143, 120); drive(120, 120);
        drive(200, 200); drive(0, 0); drive(0, 0); drive(0, 0);
        flush();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
